// File: rtl/sps_pkg.sv
// rtl/sps_pkg.sv - shared types and constants for the parking slot arbiter
package sps_pkg;

    localparam int NUM_SLOTS   = 4;
    localparam int SLOT_W      = 2;
    localparam int COUNT_VALUE = 40_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DOOR  = 2'd2
    } state_t;

    // Lowest-index clear bit; returns 0 when every slot is taken.
    function automatic logic [SLOT_W-1:0] first_free(input logic [NUM_SLOTS-1:0] s);
        first_free = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!s[i]) first_free = SLOT_W'(i);
        end
    endfunction

endpackage

// File: rtl/door_timer.sv
// rtl/door_timer.sv - loadable down-counter that flags the last door-open cycle
module door_timer #(
    parameter int COUNT_VALUE = sps_pkg::COUNT_VALUE
) (
    input  logic clk,
    input  logic reset_in,
    input  logic load,
    output logic done
);

    localparam int CNT_W = $clog2(COUNT_VALUE + 1);

    logic [CNT_W-1:0] cnt;

    // Saturates at zero so a stray extra cycle can never wrap into a long hold.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(COUNT_VALUE);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/slot_arbiter.sv
// rtl/slot_arbiter.sv - parking lot entry/exit arbiter with slot bitmap and door hold
module slot_arbiter #(
    parameter int COUNT_VALUE = sps_pkg::COUNT_VALUE,
    parameter int NUM_SLOTS   = sps_pkg::NUM_SLOTS
) (
    input  logic                      clk,
    input  logic                      reset_in,
    input  logic                      entry_req,
    input  logic                      exit_req,
    input  logic [sps_pkg::SLOT_W-1:0] exit_slot,
    output logic [NUM_SLOTS-1:0]      spots,
    output logic [sps_pkg::SLOT_W-1:0] assigned_slot,
    output logic                      grant,
    output logic                      reject,
    output logic                      exit_err,
    output logic                      door_open,
    output logic                      full
);

    import sps_pkg::*;

    state_t state, state_nxt;

    logic              entry_prev, exit_prev, armed;
    logic              pend_entry, pend_exit;
    logic              serve_exit, last_exit;
    logic [SLOT_W-1:0] exit_slot_q, free_slot;
    logic              entry_edge, exit_edge, exit_take;
    logic              clr_entry, clr_exit, release_slot, door_load, door_done;

    // armed stays low for the first clock after reset so a held level is not an edge.
    assign entry_edge = armed & entry_req & ~entry_prev;
    assign exit_edge  = armed & exit_req & ~exit_prev;
    assign exit_take  = exit_edge & (~pend_exit | clr_exit);
    assign full       = (spots == '1);
    assign free_slot  = first_free(spots);

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pend_entry || pend_exit) state_nxt = ST_SERVE;
            ST_SERVE: state_nxt = door_load ? ST_DOOR : ST_IDLE;
            ST_DOOR:  if (door_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        grant        = 1'b0;
        reject       = 1'b0;
        exit_err     = 1'b0;
        door_open    = 1'b0;
        clr_entry    = 1'b0;
        clr_exit     = 1'b0;
        release_slot = 1'b0;
        case (state)
            ST_SERVE: begin
                clr_entry    = ~serve_exit;
                clr_exit     = serve_exit;
                grant        = ~serve_exit & ~full;
                reject       = ~serve_exit & full;
                release_slot = serve_exit & spots[exit_slot_q];
                exit_err     = serve_exit & ~spots[exit_slot_q];
            end
            ST_DOOR:  door_open = 1'b1;
            default:  ;
        endcase
        door_load = grant | release_slot;
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            entry_prev    <= 1'b0;
            exit_prev     <= 1'b0;
            armed         <= 1'b0;
            pend_entry    <= 1'b0;
            pend_exit     <= 1'b0;
            serve_exit    <= 1'b0;
            last_exit     <= 1'b0;
            exit_slot_q   <= '0;
            spots         <= '0;
            assigned_slot <= '0;
        end else begin
            entry_prev <= entry_req;
            exit_prev  <= exit_req;
            armed      <= 1'b1;
            // A fresh edge in the servicing cycle re-arms the flag rather than being lost.
            pend_entry <= entry_edge | (pend_entry & ~clr_entry);
            pend_exit  <= exit_edge | (pend_exit & ~clr_exit);
            if (exit_take) exit_slot_q <= exit_slot;
            if (state == ST_IDLE && (pend_entry || pend_exit)) begin
                serve_exit <= pend_exit & (~pend_entry | ~last_exit);
            end
            if (state == ST_SERVE) last_exit <= serve_exit;
            if (grant) begin
                spots[free_slot] <= 1'b1;
                assigned_slot    <= free_slot;
            end
            if (release_slot) spots[exit_slot_q] <= 1'b0;
        end
    end

    door_timer #(.COUNT_VALUE(COUNT_VALUE)) u_door_timer (
        .clk      (clk),
        .reset_in (reset_in),
        .load     (door_load),
        .done     (door_done)
    );

endmodule

// File: tb/tb_slot_arbiter.sv
// tb/tb_slot_arbiter.sv - randomized and directed self-checking bench for slot_arbiter
module tb_slot_arbiter;

    localparam int CV = 2;

    logic       clk = 1'b0;
    logic       reset_in = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [1:0] exit_slot = 2'd0;
    logic [3:0] spots;
    logic [1:0] assigned_slot;
    logic       grant, reject, exit_err, door_open, full;

    int checks = 0;
    int errors = 0;
    int grant_cnt = 0, reject_cnt = 0, err_cnt = 0, door_cnt = 0;
    logic [3:0] spots_at_grant = 4'd0;

    always #5 clk = ~clk;

    slot_arbiter #(.COUNT_VALUE(CV), .NUM_SLOTS(4)) dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_slot     (exit_slot),
        .spots         (spots),
        .assigned_slot (assigned_slot),
        .grant         (grant),
        .reject        (reject),
        .exit_err      (exit_err),
        .door_open     (door_open),
        .full          (full)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lot occupancy, one-deep request latches, and a busy timeline
    // (a single service cycle followed by a door hold of CV cycles when it succeeds).
    bit [3:0] m_occ;
    bit [1:0] m_asg, m_xs;
    bit       m_pe, m_px, m_last_x, m_serve, m_sx, m_eprev, m_xprev, m_armed;
    int       m_door;

    always @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            m_occ = 0; m_asg = 0; m_xs = 0; m_pe = 0; m_px = 0; m_last_x = 0;
            m_serve = 0; m_sx = 0; m_eprev = 0; m_xprev = 0; m_armed = 0; m_door = 0;
        end else begin
            bit e_edge, x_edge, pe, px;
            int idx;
            e_edge = m_armed && entry_req && !m_eprev;
            x_edge = m_armed && exit_req && !m_xprev;
            pe = m_pe;
            px = m_px;
            if (m_serve) begin
                if (!m_sx) begin
                    if (m_occ != 4'hF) begin
                        idx = 0;
                        for (int i = 3; i >= 0; i--) if (!m_occ[i]) idx = i;
                        m_occ[idx] = 1'b1;
                        m_asg = 2'(idx);
                        m_door = CV;
                    end
                    pe = 0;
                end else begin
                    if (m_occ[m_xs]) begin
                        m_occ[m_xs] = 1'b0;
                        m_door = CV;
                    end
                    px = 0;
                end
                m_last_x = m_sx;
                m_serve = 0;
            end else if (m_door > 0) begin
                m_door--;
            end else if (m_pe || m_px) begin
                m_serve = 1;
                m_sx = m_px && (!m_pe || !m_last_x);
            end
            if (e_edge) pe = 1;
            if (x_edge && !px) m_xs = exit_slot;
            if (x_edge) px = 1;
            m_pe = pe;
            m_px = px;
            m_eprev = entry_req;
            m_xprev = exit_req;
            m_armed = 1;
        end
    end

    always @(negedge clk) begin
        bit mf;
        mf = (m_occ == 4'hF);
        chk("spots", spots, m_occ);
        chk("assigned_slot", assigned_slot, m_asg);
        chk("full", full, mf);
        chk("door_open", door_open, m_door > 0);
        chk("grant", grant, m_serve && !m_sx && !mf);
        chk("reject", reject, m_serve && !m_sx && mf);
        chk("exit_err", exit_err, m_serve && m_sx && !m_occ[m_xs]);
        if (grant) begin
            grant_cnt++;
            spots_at_grant = spots;
        end
        if (reject) reject_cnt++;
        if (exit_err) err_cnt++;
        if (door_open) door_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_counts();
        grant_cnt = 0; reject_cnt = 0; err_cnt = 0; door_cnt = 0;
    endtask

    task automatic do_entry();
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        tick(8);
    endtask

    task automatic do_exit(input logic [1:0] s);
        exit_slot = s;
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        tick(8);
    endtask

    initial begin
        bit seen;
        tick(3);
        chk("reset_spots", spots, 4'b0000);
        chk("reset_door", door_open, 0);
        reset_in = 1'b1;
        tick(2);

        clear_counts();
        do_entry();
        chk("t1_grant_cnt", grant_cnt, 1);
        chk("t1_assigned", assigned_slot, 0);
        chk("t1_spots", spots, 4'b0001);
        chk("t1_door_cycles", door_cnt, 2);

        repeat (3) do_entry();
        chk("t2_spots_full", spots, 4'b1111);
        chk("t2_full", full, 1);
        clear_counts();
        do_entry();
        chk("t2_reject_cnt", reject_cnt, 1);
        chk("t2_no_grant", grant_cnt, 0);
        chk("t2_no_door", door_cnt, 0);

        do_exit(2'd1);
        do_exit(2'd3);
        chk("t3_spots_0101", spots, 4'b0101);
        do_exit(2'd2);
        chk("t3_spots_0001", spots, 4'b0001);
        clear_counts();
        do_exit(2'd1);
        chk("t3_exit_err_cnt", err_cnt, 1);
        chk("t3_spots_kept", spots, 4'b0001);

        repeat (3) do_entry();
        chk("t4_spots_full", spots, 4'b1111);
        clear_counts();
        exit_slot = 2'd0;
        entry_req = 1'b1;
        exit_req = 1'b1;
        tick();
        entry_req = 1'b0;
        exit_req = 1'b0;
        tick(14);
        chk("t4_grant_cnt", grant_cnt, 1);
        chk("t4_spots_at_grant", spots_at_grant, 4'b1110);
        chk("t4_spots_final", spots, 4'b1111);
        chk("t4_assigned", assigned_slot, 0);
        chk("t4_door_cycles", door_cnt, 4);

        exit_slot = 2'd3;
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (door_open) seen = 1;
            else tick();
        end
        chk("t5_door_seen", seen, 1);
        entry_req = 1'b1;
        reset_in = 1'b0;
        #1;
        chk("t5_rst_door", door_open, 0);
        chk("t5_rst_spots", spots, 0);
        chk("t5_rst_full", full, 0);
        tick(2);
        reset_in = 1'b1;
        clear_counts();
        tick(10);
        chk("t5_no_grant", grant_cnt, 0);
        chk("t5_spots_empty", spots, 0);
        entry_req = 1'b0;
        tick(2);

        for (int it = 0; it < 600; it++) begin
            entry_req = ($urandom_range(0, 2) == 0);
            exit_req  = ($urandom_range(0, 3) == 0);
            exit_slot = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                reset_in = 1'b0;
                tick($urandom_range(1, 2));
                reset_in = 1'b1;
            end
            tick($urandom_range(1, 4));
        end
        entry_req = 1'b0;
        exit_req = 1'b0;
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
